i2c_master: RTL and testbench

I2C_MASTER -- requirements
Module: i2c_master

---
 rtl/i2c_pkg.sv | 19 +
 rtl/i2c_clk_div.sv | 38 +++
 rtl/i2c_master.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: FSM state encoding and default bit timing.
package i2c_pkg;

    // Default number of clk cycles per SCL bit period (must be even and >= 4).
    localparam int DIVIDE_BY_DEFAULT = 4;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WRITE_DATA,
        WRITE_ACK,
        READ_DATA,
        READ_ACK,
        STOP
    } state_t;

endpackage

// File: rtl/i2c_clk_div.sv
// Bit-period divider: produces the SCL phase of the current bit and the
// per-bit timing ticks (SCL rising point and last cycle of the bit).
module i2c_clk_div
    import i2c_pkg::*;
#(
    parameter int DIVIDE_BY = DIVIDE_BY_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic scl_high,
    output logic rise_tick,
    output logic bit_end
);

    localparam int CW = (DIVIDE_BY > 2) ? $clog2(DIVIDE_BY) : 1;
    localparam logic [CW-1:0] HALF = CW'(DIVIDE_BY / 2);
    localparam logic [CW-1:0] LAST = CW'(DIVIDE_BY - 1);

    logic [CW-1:0] count;

    // Cycle position inside the current bit; parked at zero while the bus is idle.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Second half of every bit is the SCL-high phase.
    assign scl_high  = (count >= HALF);
    assign rise_tick = run && (count == HALF);
    assign bit_end   = run && (count == LAST);

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte written
// or read, then STOP. SCL is always driven; SDA is push-pull when owned.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int DIVIDE_BY = DIVIDE_BY_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] addr,
    input  logic [7:0] in_data,
    input  logic       enable,
    input  logic       rw,
    output logic [7:0] out_data,
    output logic       ready,
    inout  wire        sda,
    inout  wire        scl
);

    state_t state;
    state_t next_state;

    logic       scl_high;
    logic       rise_tick;
    logic       bit_end;
    logic       accept;

    logic [2:0] bit_cnt;
    logic       rw_l;
    logic       ack_ok;
    logic [7:0] tx_shift;
    logic [7:0] data_l;
    logic [7:0] rx_shift;
    logic       sda_in;

    // Combinational bus intent for the current cycle.
    logic       scl_d;
    logic       sda_en_d;
    logic       sda_val_d;

    // Registered bus drivers. SDA carries one more register than SCL, so every
    // SDA change lands one clk after the SCL edge that precedes it: data moves
    // well inside the SCL-low window and START/STOP edges sit inside SCL-high.
    logic       scl_p1;
    logic       sda_en_p1;
    logic       sda_val_p1;
    logic       sda_en_p2;
    logic       sda_val_p2;

    assign accept = (state == IDLE) && ready && enable;
    assign sda_in = sda;

    i2c_clk_div #(
        .DIVIDE_BY (DIVIDE_BY)
    ) u_clk_div (
        .clk       (clk),
        .reset     (reset),
        .run       (state != IDLE),
        .scl_high  (scl_high),
        .rise_tick (rise_tick),
        .bit_end   (bit_end)
    );

    // State register; reset aborts any transfer on the spot without a STOP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-state SCL/SDA intent.
    always_comb begin
        next_state = state;
        scl_d      = 1'b1;
        sda_en_d   = 1'b1;
        sda_val_d  = 1'b1;
        case (state)
            IDLE: begin
                if (accept) next_state = START;
            end
            START: begin
                // SDA falls while SCL is still high, then SCL drops.
                scl_d     = !scl_high;
                sda_val_d = 1'b0;
                if (bit_end) next_state = ADDR;
            end
            ADDR: begin
                scl_d     = scl_high;
                sda_val_d = tx_shift[7];
                if (bit_end && bit_cnt == 3'd7) next_state = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl_d    = scl_high;
                sda_en_d = 1'b0;
                if (bit_end) begin
                    if (!ack_ok)   next_state = STOP;
                    else if (rw_l) next_state = READ_DATA;
                    else           next_state = WRITE_DATA;
                end
            end
            WRITE_DATA: begin
                scl_d     = scl_high;
                sda_val_d = tx_shift[7];
                if (bit_end && bit_cnt == 3'd7) next_state = WRITE_ACK;
            end
            WRITE_ACK: begin
                scl_d    = scl_high;
                sda_en_d = 1'b0;
                if (bit_end) next_state = STOP;
            end
            READ_DATA: begin
                scl_d    = scl_high;
                sda_en_d = 1'b0;
                if (bit_end && bit_cnt == 3'd7) next_state = READ_ACK;
            end
            READ_ACK: begin
                // Master NACKs: only one byte is ever read.
                scl_d     = scl_high;
                sda_val_d = 1'b1;
                if (bit_end) next_state = STOP;
            end
            STOP: begin
                // SDA held low through SCL rise, released high on the last cycle.
                scl_d     = scl_high;
                sda_val_d = bit_end;
                if (bit_end) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Control registers: handshake, bit counting, ACK capture and read result.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready    <= 1'b0;
            bit_cnt  <= 3'd0;
            rw_l     <= 1'b0;
            ack_ok   <= 1'b0;
            out_data <= 8'h00;
        end else begin
            ready <= (next_state == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        rw_l    <= rw;
                        bit_cnt <= 3'd0;
                    end
                end
                ADDR, WRITE_DATA: begin
                    if (bit_end) bit_cnt <= bit_cnt + 3'd1;
                end
                ADDR_ACK: begin
                    if (rise_tick) ack_ok <= (sda_in == 1'b0);
                    if (bit_end)   bit_cnt <= 3'd0;
                end
                READ_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) out_data <= rx_shift;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Shift registers: transmit byte (address then data) and receive byte.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    tx_shift <= {addr, rw};
                    data_l   <= in_data;
                end
            end
            ADDR, WRITE_DATA: begin
                if (bit_end) tx_shift <= {tx_shift[6:0], 1'b0};
            end
            ADDR_ACK: begin
                if (bit_end) tx_shift <= data_l;
            end
            READ_DATA: begin
                if (rise_tick) rx_shift <= {rx_shift[6:0], sda_in};
            end
            default: begin
            end
        endcase
    end

    // Output register stages for SCL and SDA.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_p1     <= 1'b1;
            sda_en_p1  <= 1'b1;
            sda_val_p1 <= 1'b1;
            sda_en_p2  <= 1'b1;
            sda_val_p2 <= 1'b1;
        end else begin
            scl_p1     <= scl_d;
            sda_en_p1  <= sda_en_d;
            sda_val_p1 <= sda_val_d;
            sda_en_p2  <= sda_en_p1;
            sda_val_p2 <= sda_val_p1;
        end
    end

    assign scl = scl_p1;
    assign sda = sda_en_p2 ? sda_val_p2 : 1'bz;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: behavioural slave at 7'h2A returning 8'h55, pullup on
// SDA, bus monitor recording each transfer, and an expectation queue.
module tb_i2c_master;

    localparam logic [6:0] SLV_ADDR = 7'h2A;

    localparam int PH_IDLE  = 0;
    localparam int PH_ADDR  = 1;
    localparam int PH_AACK  = 2;
    localparam int PH_WDATA = 3;
    localparam int PH_WACK  = 4;
    localparam int PH_RDATA = 5;
    localparam int PH_RACK  = 6;
    localparam int PH_DONE  = 7;

    typedef struct packed {
        logic [7:0] addr_byte;
        logic       aack;
        logic [7:0] wdata;
        logic       mack;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] addr = 7'h00;
    logic [7:0] in_data = 8'h00;
    logic       enable = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] out_data;
    logic       ready;
    wire        sda;
    wire        scl;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    // Slave/monitor state
    logic       sl_low = 1'b0;
    logic       sl_want = 1'b0;
    logic       scl_prev = 1'bx;
    logic       sda_prev = 1'bx;
    logic [7:0] slv_rdata = 8'h55;
    logic       slv_match = 1'b0;
    logic       slv_read = 1'b0;
    logic       mon_ignore = 1'b0;
    int         mon_phase = PH_IDLE;
    int         mon_bits = 0;
    logic [7:0] mon_shift = 8'h00;
    logic [7:0] cur_addr = 8'h00;
    logic       cur_aack = 1'b1;
    logic [7:0] cur_wdata = 8'h00;
    logic       cur_mack = 1'b0;
    int         start_count = 0;
    int         stop_count = 0;
    logic [7:0] obs_addr [16];
    logic       obs_aack [16];
    logic [7:0] obs_wdata [16];
    logic       obs_mack [16];

    pullup (sda);
    assign sda = sl_low ? 1'b0 : 1'bz;

    i2c_master #(.DIVIDE_BY(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .in_data  (in_data),
        .enable   (enable),
        .rw       (rw),
        .out_data (out_data),
        .ready    (ready),
        .sda      (sda),
        .scl      (scl)
    );

    always #5 clk = ~clk;

    // Slave output: applies the planned SDA level one clk after SCL falls.
    always begin
        @(negedge scl);
        @(posedge clk);
        sl_low = sl_want;
    end

    // Bus monitor and slave protocol decoder.
    always begin
        @(scl or sda);
        if (scl_prev === 1'b1 && scl === 1'b1 && sda_prev === 1'b1 && sda === 1'b0) begin
            start_count++;
            mon_phase = PH_ADDR;
            mon_bits  = 0;
            mon_shift = 8'h00;
            cur_addr  = 8'h00;
            cur_aack  = 1'b1;
            cur_wdata = 8'h00;
            cur_mack  = 1'b0;
            sl_want   = 1'b0;
        end else if (scl_prev === 1'b1 && scl === 1'b1 && sda_prev === 1'b0 && sda === 1'b1) begin
            if (!mon_ignore && stop_count < 16) begin
                obs_addr[stop_count]  = cur_addr;
                obs_aack[stop_count]  = cur_aack;
                obs_wdata[stop_count] = cur_wdata;
                obs_mack[stop_count]  = cur_mack;
                stop_count++;
            end
            mon_phase = PH_IDLE;
        end else if (scl_prev === 1'b0 && scl === 1'b1) begin
            case (mon_phase)
                PH_ADDR: begin
                    mon_shift = {mon_shift[6:0], sda};
                    mon_bits++;
                    if (mon_bits == 8) begin
                        cur_addr  = mon_shift;
                        slv_match = (mon_shift[7:1] == SLV_ADDR);
                        slv_read  = mon_shift[0];
                        mon_phase = PH_AACK;
                    end
                end
                PH_AACK: begin
                    cur_aack  = sda;
                    mon_bits  = 0;
                    mon_shift = 8'h00;
                    if (sda === 1'b0) mon_phase = slv_read ? PH_RDATA : PH_WDATA;
                    else              mon_phase = PH_DONE;
                end
                PH_WDATA: begin
                    mon_shift = {mon_shift[6:0], sda};
                    mon_bits++;
                    if (mon_bits == 8) begin
                        cur_wdata = mon_shift;
                        mon_phase = PH_WACK;
                    end
                end
                PH_WACK: mon_phase = PH_DONE;
                PH_RDATA: begin
                    mon_bits++;
                    if (mon_bits == 8) mon_phase = PH_RACK;
                end
                PH_RACK: begin
                    cur_mack  = sda;
                    mon_phase = PH_DONE;
                end
                default: begin
                end
            endcase
        end else if (scl_prev === 1'b1 && scl === 1'b0) begin
            case (mon_phase)
                PH_AACK:  sl_want = slv_match;
                PH_WACK:  sl_want = 1'b1;
                PH_RDATA: sl_want = ~slv_rdata[7 - mon_bits];
                default:  sl_want = 1'b0;
            endcase
        end
        scl_prev = scl;
        sda_prev = sda;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_ready(input int limit);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    // One complete transfer; optionally pulses enable again while busy.
    task automatic run_txn(input string name, input logic [6:0] a, input logic [7:0] d,
                           input logic r, input logic extra_enable);
        exp_t e;
        exp_t got;
        int   base_stop;
        int   base_start;
        wait_ready(50);
        @(negedge clk);
        addr    = a;
        in_data = d;
        rw      = r;
        enable  = 1'b1;
        e.addr_byte = {a, r};
        e.aack      = (a != SLV_ADDR);
        e.wdata     = (!e.aack && !r) ? d : 8'h00;
        e.mack      = !e.aack && r;
        exp_q.push_back(e);
        base_stop  = stop_count;
        base_start = start_count;
        @(posedge clk);
        #1;
        check({name, "_ready_drop"}, 32'(ready), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        if (extra_enable) begin
            repeat (10) @(negedge clk);
            addr    = 7'h11;
            in_data = ~d;
            rw      = ~r;
            enable  = 1'b1;
            @(negedge clk);
            enable  = 1'b0;
        end
        wait_ready(400);
        check({name, "_ready_back"}, 32'(ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_stops"}, 32'(stop_count), 32'(base_stop + 1));
        check({name, "_starts"}, 32'(start_count), 32'(base_start + 1));
        if (stop_count > base_stop && exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {obs_addr[base_stop], obs_aack[base_stop], obs_wdata[base_stop], obs_mack[base_stop]};
            check({name, "_addr_byte"}, 32'(got.addr_byte), 32'(e.addr_byte));
            check({name, "_addr_ack"},  32'(got.aack),      32'(e.aack));
            check({name, "_wdata"},     32'(got.wdata),     32'(e.wdata));
            check({name, "_master_ack"}, 32'(got.mack),     32'(e.mack));
        end
    endtask

    initial begin
        int n;
        // Reset held 100 ns
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_out", 32'(out_data), 32'h00);
        #(100 - 26);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(ready), 32'd1);
        check("post_rst_scl", 32'(scl), 32'd1);
        check("post_rst_sda", 32'(sda), 32'd1);
        check("post_rst_out", 32'(out_data), 32'h00);

        run_txn("wr_aa", 7'h2A, 8'hAA, 1'b0, 1'b0);
        check("wr_aa_out_kept", 32'(out_data), 32'h00);

        run_txn("rd_55", 7'h2A, 8'h00, 1'b1, 1'b0);
        check("rd_55_out", 32'(out_data), 32'h55);

        run_txn("nack", 7'h11, 8'h00, 1'b1, 1'b0);
        check("nack_out_kept", 32'(out_data), 32'h55);

        run_txn("busy_en", 7'h2A, 8'h5A, 1'b0, 1'b1);
        check("busy_en_out_kept", 32'(out_data), 32'h55);

        // Abort a write in the middle of its data byte
        wait_ready(50);
        @(negedge clk);
        addr = 7'h2A; in_data = 8'h3C; rw = 1'b0; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (!(mon_phase == PH_WDATA && mon_bits >= 3) && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("abort_reached_wdata", 32'(mon_phase), 32'(PH_WDATA));
        mon_ignore = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_scl", 32'(scl), 32'd1);
        check("abort_sda", 32'(sda), 32'd1);
        check("abort_out", 32'(out_data), 32'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready_after", 32'(ready), 32'd1);
        repeat (4) @(posedge clk);
        mon_ignore = 1'b0;

        run_txn("wr_c3", 7'h2A, 8'hC3, 1'b0, 1'b0);
        check("wr_c3_out_kept", 32'(out_data), 32'h00);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
